// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: enables data reporting (0xF4 -> 0xFA, with retries), then decodes 3-byte stream packets.
// Latency: xm/ym/btnm and m_done_tick update 1 cycle after the third byte's rx_done_tick; init_done 1 cycle after the ACK.
// No backpressure: all link events are single-cycle ticks. Define PS2_RESET_SEQ_EN to prepend the 0xFF/0xFA/0xAA/0x00 reset preamble.
module ps2_mouse_ctrl #(
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int CW          = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btnm,
    output logic       m_done_tick,
    output logic       init_done,
    output logic       init_err
);

`ifdef PS2_RESET_SEQ_EN
    localparam int TW = CW + 6;
`else
    localparam int TW = CW;
`endif
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        SEND,
        WAIT_TX,
        WAIT_ACK,
        PKT1,
        PKT2,
        PKT3,
        FAIL
`ifdef PS2_RESET_SEQ_EN
        ,
        SEND_RST,
        WAIT_TX_RST,
        WAIT_ACK_RST,
        WAIT_BAT,
        WAIT_ID
`endif
    } state_t;

`ifdef PS2_RESET_SEQ_EN
    localparam state_t RESTART = SEND_RST;
    // Self-test can take far longer than a command ACK, hence the wider counter.
    localparam logic [TW-1:0] BAT_LAST = TW'(64 * ACK_TIMEOUT - 1);
`else
    localparam state_t RESTART = SEND;
`endif

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   retry_cnt;
    logic [7:0]      b2;
    logic [2:0]      b1_btn;
    logic            b1_xs;
    logic            b1_ys;

    logic            in_wait;
    logic [7:0]      expect_byte;
    logic [TW-1:0]   tlimit;
    logic            wait_pass;
    logic            wait_fault;

    // Every reply-wait state shares one pass/fault decision; a received byte beats a timeout.
    always_comb begin
        in_wait     = 1'b0;
        expect_byte = 8'hFA;
        tlimit      = ACK_LAST;
        case (state)
            WAIT_ACK: in_wait = 1'b1;
`ifdef PS2_RESET_SEQ_EN
            WAIT_ACK_RST: in_wait = 1'b1;
            WAIT_BAT: begin
                in_wait     = 1'b1;
                expect_byte = 8'hAA;
                tlimit      = BAT_LAST;
            end
            WAIT_ID: begin
                in_wait     = 1'b1;
                expect_byte = 8'h00;
            end
`endif
            default: ;
        endcase
        wait_pass  = in_wait && rx_done_tick && (rx_data == expect_byte);
        wait_fault = in_wait && (rx_done_tick ? (rx_data != expect_byte) : (tcnt == tlimit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESTART;
            tcnt        <= '0;
            retry_cnt   <= '0;
            wr_ps2      <= 1'b0;
            tx_data     <= 8'hF4;
            xm          <= '0;
            ym          <= '0;
            btnm        <= '0;
            m_done_tick <= 1'b0;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            b2          <= '0;
            b1_btn      <= '0;
            b1_xs       <= 1'b0;
            b1_ys       <= 1'b0;
        end else begin
            wr_ps2      <= 1'b0;
            m_done_tick <= 1'b0;
            if (wait_fault) begin
                if (retry_cnt < RETRY_MAX) begin
                    retry_cnt <= retry_cnt + 1'b1;
                    state     <= RESTART;
                end else begin
                    init_err <= 1'b1;
                    state    <= FAIL;
                end
            end else if (wait_pass) begin
                tcnt <= '0;
                case (state)
                    WAIT_ACK: begin
                        init_done <= 1'b1;
                        state     <= PKT1;
                    end
`ifdef PS2_RESET_SEQ_EN
                    WAIT_ACK_RST: state <= WAIT_BAT;
                    WAIT_BAT:     state <= WAIT_ID;
                    WAIT_ID:      state <= SEND;
`endif
                    default: ;
                endcase
            end else begin
                case (state)
                    SEND: begin
                        wr_ps2  <= 1'b1;
                        tx_data <= 8'hF4;
                        state   <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (tx_done_tick) begin
                            tcnt  <= '0;
                            state <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: tcnt <= tcnt + 1'b1;
`ifdef PS2_RESET_SEQ_EN
                    SEND_RST: begin
                        wr_ps2  <= 1'b1;
                        tx_data <= 8'hFF;
                        state   <= WAIT_TX_RST;
                    end
                    WAIT_TX_RST: begin
                        if (tx_done_tick) begin
                            tcnt  <= '0;
                            state <= WAIT_ACK_RST;
                        end
                    end
                    WAIT_ACK_RST, WAIT_BAT, WAIT_ID: tcnt <= tcnt + 1'b1;
`endif
                    // Bit 3 of the first byte is always set; use it to resynchronise.
                    PKT1: begin
                        if (rx_done_tick && rx_data[3]) begin
                            b1_btn <= rx_data[2:0];
                            b1_xs  <= rx_data[4];
                            b1_ys  <= rx_data[5];
                            state  <= PKT2;
                        end
                    end
                    PKT2: begin
                        if (rx_done_tick) begin
                            b2    <= rx_data;
                            state <= PKT3;
                        end
                    end
                    PKT3: begin
                        if (rx_done_tick) begin
                            xm          <= {b1_xs, b2};
                            ym          <= {b1_ys, rx_data};
                            btnm        <= b1_btn;
                            m_done_tick <= 1'b1;
                            state       <= PKT1;
                        end
                    end
                    FAIL: ;
                    default: state <= RESTART;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl (default build): init handshake, packet table, resync, retry/timeout, mid-packet reset.
module tb_ps2_mouse_ctrl;
    localparam int ACK_TO = 200;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btnm;
    logic       m_done_tick;
    logic       init_done;
    logic       init_err;

    always #5 clk = ~clk;

    ps2_mouse_ctrl #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRY(MAXR), .CW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .tx_done_tick (tx_done_tick),
        .wr_ps2       (wr_ps2),
        .tx_data      (tx_data),
        .xm           (xm),
        .ym           (ym),
        .btnm         (btnm),
        .m_done_tick  (m_done_tick),
        .init_done    (init_done),
        .init_err     (init_err)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int md_cnt = 0;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (wr_ps2) wr_cnt++;
        if (m_done_tick) md_cnt++;
    end

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [8:0] exm;
        logic [8:0] eym;
        logic [2:0] ebtn;
    } pkt_t;
    pkt_t vec[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic tx_ack();
        repeat (5) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_wr(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (wr_ps2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic init_seq(input logic [7:0] reply);
        int n;
        bit ok;
        wait_wr(n, ok);
        check("wr_seen", 32'(ok), 32'd1);
        check("tx_data", 32'(tx_data), 32'hF4);
        tx_ack();
        repeat (100) @(negedge clk);
        send_rx(reply);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0;
        int  m0;
        int  n;
        bit  ok;

        vec[0] = '{8'h29, 8'h05, 8'hFB, 9'h005, 9'h1FB, 3'b001};
        vec[1] = '{8'h08, 8'h00, 8'h00, 9'h000, 9'h000, 3'b000};
        vec[2] = '{8'h3F, 8'hFF, 8'hFF, 9'h1FF, 9'h1FF, 3'b111};
        vec[3] = '{8'hC9, 8'h7F, 8'h80, 9'h07F, 9'h080, 3'b001};
        vec[4] = '{8'h1A, 8'h00, 8'h7F, 9'h100, 9'h07F, 3'b010};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_xm", 32'(xm), 32'h0);
        check("rst_ym", 32'(ym), 32'h0);
        check("rst_btnm", 32'(btnm), 32'h0);
        check("rst_mdone", 32'(m_done_tick), 32'h0);
        check("rst_wr", 32'(wr_ps2), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'hF4);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_init_err", 32'(init_err), 32'h0);
        reset = 1'b0;

        // Basic init handshake.
        w0 = wr_cnt;
        wait_wr(n, ok);
        check("wr_after_reset", 32'(ok), 32'd1);
        check("tx_data_f4", 32'(tx_data), 32'hF4);
        tx_ack();
        repeat (100) @(negedge clk);
        check("init_done_pre", 32'(init_done), 32'h0);
        send_rx(8'hFA);
        check("init_done", 32'(init_done), 32'h1);
        check("init_err", 32'(init_err), 32'h0);
        check("wr_pulses_1", 32'(wr_cnt - w0), 32'd1);

        // Packet table.
        for (int i = 0; i < 5; i++) begin
            m0 = md_cnt;
            send_rx(vec[i].b1);
            send_rx(vec[i].b2);
            check("mdone_early", 32'(m_done_tick), 32'h0);
            send_rx(vec[i].b3);
            check("mdone", 32'(m_done_tick), 32'h1);
            check("xm", 32'(xm), 32'(vec[i].exm));
            check("ym", 32'(ym), 32'(vec[i].eym));
            check("btnm", 32'(btnm), 32'(vec[i].ebtn));
            @(negedge clk);
            check("mdone_len", 32'(m_done_tick), 32'h0);
            check("mdone_count", 32'(md_cnt - m0), 32'd1);
        end
        repeat (10) @(negedge clk);
        check("xm_hold", 32'(xm), 32'h100);
        check("ym_hold", 32'(ym), 32'h07F);

        // Lost sync: 0x05 has bit3 clear and must be dropped.
        m0 = md_cnt;
        send_rx(8'h05);
        send_rx(8'h1E);
        send_rx(8'h80);
        check("sync_no_early", 32'(m_done_tick), 32'h0);
        send_rx(8'h01);
        check("sync_mdone", 32'(m_done_tick), 32'h1);
        check("sync_xm", 32'(xm), 32'h180);
        check("sync_ym", 32'(ym), 32'h001);
        check("sync_btnm", 32'(btnm), 32'h6);
        @(negedge clk);
        check("sync_count", 32'(md_cnt - m0), 32'd1);

        // Reset in the middle of a packet.
        send_rx(8'h29);
        send_rx(8'h05);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_xm", 32'(xm), 32'h0);
        check("mid_rst_init", 32'(init_done), 32'h0);
        reset = 1'b0;
        m0 = md_cnt;
        init_seq(8'hFA);
        check("reinit_done", 32'(init_done), 32'h1);
        check("reinit_xm", 32'(xm), 32'h0);
        check("reinit_ym", 32'(ym), 32'h0);
        check("reinit_btnm", 32'(btnm), 32'h0);
        check("reinit_no_md", 32'(md_cnt - m0), 32'd0);
        send_rx(8'h2A);
        send_rx(8'h10);
        send_rx(8'h20);
        check("reinit_pkt_md", 32'(m_done_tick), 32'h1);
        check("reinit_pkt_xm", 32'(xm), 32'h010);
        check("reinit_pkt_ym", 32'(ym), 32'h120);
        check("reinit_pkt_btn", 32'(btnm), 32'h2);

        // NAK then ACK.
        do_reset();
        w0 = wr_cnt;
        init_seq(8'hFE);
        check("nak_no_done", 32'(init_done), 32'h0);
        wait_wr(n, ok);
        check("nak_resend", 32'(ok), 32'd1);
        check("nak_tx_data", 32'(tx_data), 32'hF4);
        tx_ack();
        repeat (20) @(negedge clk);
        send_rx(8'hFA);
        check("nak_init_done", 32'(init_done), 32'h1);
        check("nak_init_err", 32'(init_err), 32'h0);
        check("nak_wr_pulses", 32'(wr_cnt - w0), 32'd2);

        // Silent device: retries spaced by the timeout, then FAIL.
        do_reset();
        w0 = wr_cnt;
        wait_wr(n, ok);
        check("to_wr1", 32'(ok), 32'd1);
        tx_ack();
        wait_wr(n, ok);
        check("to_wr2", 32'(ok), 32'd1);
        check("to_gap2", 32'(6 + n), 32'd207);
        tx_ack();
        wait_wr(n, ok);
        check("to_wr3", 32'(ok), 32'd1);
        check("to_gap3", 32'(6 + n), 32'd207);
        tx_ack();
        repeat (190) @(negedge clk);
        check("to_err_early", 32'(init_err), 32'h0);
        repeat (15) @(negedge clk);
        check("to_init_err", 32'(init_err), 32'h1);
        check("to_init_done", 32'(init_done), 32'h0);
        check("to_wr_pulses", 32'(wr_cnt - w0), 32'd3);
        m0 = md_cnt;
        send_rx(8'hFA);
        send_rx(8'h08);
        send_rx(8'h00);
        send_rx(8'h00);
        repeat (300) @(negedge clk);
        check("fail_no_md", 32'(md_cnt - m0), 32'd0);
        check("fail_no_done", 32'(init_done), 32'h0);
        check("fail_err_held", 32'(init_err), 32'h1);
        check("fail_no_wr", 32'(wr_cnt - w0), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
